// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: oversampling UART receiver with an ASCII command decoder for
// a Bluetooth serial link. Digits '1'.. select a one-hot position and letters
// 'A'.. select a mode index; both selections are held between commands.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data
// bits and drives parity_err; otherwise parity_err is tied low).
module uart_cmd_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int N_POS      = 5,
  parameter int N_MODE     = 2,
  parameter int PARITY_ODD = 0,
  localparam int MW        = (N_MODE > 1) ? $clog2(N_MODE) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 cmd_valid,
  output logic [N_POS-1:0]     pos_sel,
  output logic [MW-1:0]        mode_sel
);

  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVS);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SUB_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  // Elaboration-time parameter range checks
  if (OVS < 8 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_cmd_rx: OVS must be even and >= 8");
  end
  if (DATA_BITS < 7 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_cmd_rx: DATA_BITS must be 7 or 8");
  end
  if (N_POS < 1 || N_POS > 9) begin : g_bad_pos
    $error("uart_cmd_rx: N_POS must be 1..9");
  end
  if (N_MODE < 1 || N_MODE > 26) begin : g_bad_mode
    $error("uart_cmd_rx: N_MODE must be 1..26");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_cmd_rx: PARITY_ODD must be 0 or 1");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_cmd_rx: CLK_HZ too low for BAUD*OVS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [DW-1:0]        r_div;
  logic                 w_tick;

  state_t               r_state;
  state_t               w_state_n;
  logic [SW-1:0]        r_sub;
  logic [SW-1:0]        w_sub_n;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_n;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_n;
  logic                 w_valid_n;
  logic                 w_ferr_n;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  logic [7:0]           w_byte;
  logic [7:0]           w_pos_k;
  logic [7:0]           w_mode_k;
  logic                 w_pos_hit;
  logic                 w_mode_hit;
  logic [N_POS-1:0]     w_pos_onehot;
  logic                 r_cmd_valid;
  logic [N_POS-1:0]     r_pos_sel;
  logic [MW-1:0]        r_mode_sel;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic r_par_bad;
  logic w_par_bad_n;
  logic w_perr_n;
  logic r_parity_err;
`endif

  // Two-flop synchroniser for the asynchronous line; idles high out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Free-running oversample tick divider, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  // Frame FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sub       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_sub       <= w_sub_n;
      r_bit       <= w_bit_n;
      r_shift     <= w_shift_n;
      r_rx_valid  <= w_valid_n;
      r_frame_err <= w_ferr_n;
      if (w_valid_n) begin
        r_rx_data <= r_shift;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict carried from the parity bit to the stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bad    <= w_par_bad_n;
      r_parity_err <= w_perr_n;
    end
  end
`endif

  // Next-state and strobe decode; everything moves only on an oversample tick
  always_comb begin
    w_state_n = r_state;
    w_sub_n   = r_sub;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_n = r_par_bad;
    w_perr_n    = 1'b0;
`endif
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_n = S_START;
            w_sub_n   = '0;
          end
        end
        S_START: begin
          if (r_sub == SUB_HALF) begin
            if (r_rx_s) begin
              w_state_n = S_IDLE;
            end else begin
              w_state_n = S_DATA;
              w_sub_n   = '0;
              w_bit_n   = '0;
            end
          end else begin
            w_sub_n = r_sub + 1'b1;
          end
        end
        S_DATA: begin
          if (r_sub == SUB_LAST) begin
            w_shift_n = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_sub_n   = '0;
            if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_n = S_PARITY;
`else
              w_state_n = S_STOP;
`endif
            end else begin
              w_bit_n = r_bit + 1'b1;
            end
          end else begin
            w_sub_n = r_sub + 1'b1;
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (r_sub == SUB_LAST) begin
            w_par_bad_n = ((^r_shift) ^ r_rx_s) != PAR_ODD;
            w_state_n   = S_STOP;
            w_sub_n     = '0;
          end else begin
            w_sub_n = r_sub + 1'b1;
          end
`else
          w_state_n = S_IDLE;
`endif
        end
        S_STOP: begin
          if (r_sub == SUB_LAST) begin
            if (r_rx_s) begin
              // A framing error takes precedence, so parity is judged only here
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                w_perr_n = 1'b1;
              end else begin
                w_valid_n = 1'b1;
              end
`else
              w_valid_n = 1'b1;
`endif
              w_state_n = S_IDLE;
            end else begin
              w_ferr_n  = 1'b1;
              w_state_n = S_BREAK;
            end
          end else begin
            w_sub_n = r_sub + 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            w_state_n = S_IDLE;
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  // Command match on the received byte, zero-extended to 8 bits
  always_comb begin
    w_byte       = 8'(r_rx_data);
    w_pos_k      = w_byte - 8'h31;
    w_mode_k     = w_byte - 8'h41;
    w_pos_hit    = (w_byte >= 8'h31) && (w_pos_k < 8'(N_POS));
    w_mode_hit   = (w_byte >= 8'h41) && (w_mode_k < 8'(N_MODE));
    w_pos_onehot = '0;
    for (int unsigned k = 0; k < N_POS; k++) begin
      w_pos_onehot[k] = (w_pos_k == 8'(k));
    end
  end

  // Apply a recognised command the clock after rx_valid; selections are held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_pos_sel   <= N_POS'(1);
      r_mode_sel  <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (r_rx_valid) begin
        if (w_pos_hit) begin
          r_pos_sel   <= w_pos_onehot;
          r_cmd_valid <= 1'b1;
        end else if (w_mode_hit) begin
          r_mode_sel  <= w_mode_k[MW-1:0];
          r_cmd_valid <= 1'b1;
        end
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign cmd_valid = r_cmd_valid;
  assign pos_sel   = r_pos_sel;
  assign mode_sel  = r_mode_sel;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed frames with a queue-based scoreboard.
// The clock is scaled so one bit is exactly 160 clocks (DIV=10, OVS=16),
// keeping the run short while the bit period stays an exact tick multiple.
`timescale 1ns/10ps
module tb_uart_cmd_rx;

  localparam int CLK_HZ   = 1_536_000;
  localparam int BIT_CLKS = 160;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       cmd_valid;
  logic [4:0] pos_sel;
  logic [0:0] mode_sel;

  uart_cmd_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (9600),
    .OVS       (16),
    .DATA_BITS (8),
    .N_POS     (5),
    .N_MODE    (2),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .cmd_valid (cmd_valid),
    .pos_sel   (pos_sel),
    .mode_sel  (mode_sel)
  );

  initial clk = 1'b0;
  always #325.52 clk = ~clk;

  // kind: 0 rx_valid, 1 frame_err, 2 parity_err, 3 cmd_valid
  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [4:0] pos;
    logic [0:0] mode;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  logic prev_rxv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic push_ev(input int k, input logic [7:0] d, input logic [4:0] p, input logic [0:0] m);
    ev_t e;
    e.kind = k; e.data = d; e.pos = p; e.mode = m;
    exp_q.push_back(e);
  endtask

  task automatic take(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_strobe_kind", 32'(k), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("strobe_kind", 32'(k), 32'(e.kind));
      if (k == 0 && e.kind == 0) chk("rx_data", 32'(rx_data), 32'(e.data));
      if (k == 3 && e.kind == 3) begin
        chk("cmd_pos_sel", 32'(pos_sel), 32'(e.pos));
        chk("cmd_mode_sel", 32'(mode_sel), 32'(e.mode));
        chk("cmd_latency", 32'(prev_rxv), 32'd1);
      end
    end
  endtask

  // Monitor: pops and compares whenever the DUT raises a strobe
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid)   take(0);
      if (frame_err)  take(1);
      if (parity_err) take(2);
      if (cmd_valid)  take(3);
      prev_rxv = rx_valid;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_v);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_v;
    wait_clks(BIT_CLKS);
`else
    if (par_v === 1'bx) rx = 1'b1;
`endif
    rx = stop_v;
    wait_clks(BIT_CLKS);
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic good_frame(input logic [7:0] b);
    send_byte(b, 1'b1, even_par(b));
  endtask

  task automatic drain(input string nm);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(2);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_pos_sel", 32'(pos_sel), 32'b00001);
    chk("reset_mode_sel", 32'(mode_sel), 32'd0);
    chk("reset_strobes", 32'({rx_valid, frame_err, parity_err, cmd_valid}), 32'd0);

    // '3' selects position 3
    push_ev(0, 8'h33, 5'b0, 1'b0);
    push_ev(3, 8'h00, 5'b00100, 1'b0);
    good_frame(8'h33);
    drain("t1_drained");

    // 'B' then '5' back to back
    push_ev(0, 8'h42, 5'b0, 1'b0);
    push_ev(3, 8'h00, 5'b00100, 1'b1);
    push_ev(0, 8'h35, 5'b0, 1'b0);
    push_ev(3, 8'h00, 5'b10000, 1'b1);
    good_frame(8'h42);
    good_frame(8'h35);
    drain("t2_drained");

    // 'Z' is received but is not a command
    push_ev(0, 8'h5A, 5'b0, 1'b0);
    good_frame(8'h5A);
    drain("t3_drained");
    chk("t3_pos_held", 32'(pos_sel), 32'b10000);
    chk("t3_mode_held", 32'(mode_sel), 32'd1);

    // Framing error followed by a held break, then a clean '2'
    push_ev(1, 8'h00, 5'b0, 1'b0);
    send_byte(8'h31, 1'b0, even_par(8'h31));
    wait_clks(3 * BIT_CLKS);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    chk("t4_ferr_seen", 32'(exp_q.size()), 32'd0);
    chk("t4_pos_held", 32'(pos_sel), 32'b10000);
    chk("t4_data_held", 32'(rx_data), 32'h5A);
    push_ev(0, 8'h32, 5'b0, 1'b0);
    push_ev(3, 8'h00, 5'b00010, 1'b1);
    good_frame(8'h32);
    drain("t4_drained");

    // Short low glitch while idle, then 'A'
    rx = 1'b0;
    wait_clks(6);
    rx = 1'b1;
    drain("t5_glitch_quiet");
    push_ev(0, 8'h41, 5'b0, 1'b0);
    push_ev(3, 8'h00, 5'b00010, 1'b0);
    good_frame(8'h41);
    drain("t5_drained");

    // Reset in the middle of data bit 3 of '4'; sender abandons the frame
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h34 >> i) & 8'h01;
      wait_clks(BIT_CLKS);
    end
    rx = 1'b0;
    wait_clks(BIT_CLKS / 2);
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(1);
    reset = 1'b0;
    drain("t6_no_strobes");
    chk("t6_pos_reset", 32'(pos_sel), 32'b00001);
    chk("t6_data_reset", 32'(rx_data), 32'h00);
    chk("t6_mode_reset", 32'(mode_sel), 32'd0);
    push_ev(0, 8'h32, 5'b0, 1'b0);
    push_ev(3, 8'h00, 5'b00010, 1'b0);
    good_frame(8'h32);
    drain("t6_recovered");

`ifdef UART_RX_PARITY_EN
    // '1' with a wrong even-parity bit
    push_ev(2, 8'h00, 5'b0, 1'b0);
    send_byte(8'h31, 1'b1, 1'b0);
    drain("t7_drained");
    chk("t7_pos_held", 32'(pos_sel), 32'b00010);
    chk("t7_data_held", 32'(rx_data), 32'h32);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
